keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Upstream stage of keypad_decoder: scans a 4x4 matrix keypad and debounces one key press.
//  Drives one active-low column at a time and samples the active-low rows.
//  Emits held one-hot row_keys/col_keys for keypad_decoder, plus a one-cycle key_valid per press.
// PARAMETERS
//  SCAN_CYCLES      4  clk cycles each column is driven before rows are sampled; >=2, >=3 with sync
//  DEBOUNCE_CYCLES  8  consecutive stable cycles required to accept a press or a release; >=2
// PORTS
//  clk        in   1  system clock; sole clock domain
//  reset      in   1  synchronous, active-high reset
//  row_n      in   4  keypad rows, pulled up; low = pressed key in the driven column
//  col_n      out  4  column drive, active-low one-hot
//  row_keys   out  4  one-hot row of last accepted key; feeds keypad_decoder
//  col_keys   out  4  one-hot column of last accepted key; feeds keypad_decoder
//  key_valid  out  1  one-cycle pulse when a press is accepted
//  key_held   out  1  high from acceptance until the release is accepted
// BEHAVIOUR
//  Reset (sync, high): state SCAN, col_n=4'b1110, row_keys=col_keys=0, key_valid=0, key_held=0,
//   dwell/debounce counters=0. Reset asserted mid-debounce or mid-hold aborts it; no pulse.
//  rows_s = row_n as seen by FSM (see CONFIGURATION); pressed = ~rows_s.
//  SCAN: dwell counter runs 0..SCAN_CYCLES-1 on the current column; sample only on last dwell cycle.
//   - pressed is exactly one-hot: capture row/col, freeze col_n, go DEB_PRESS, debounce cnt=0.
//   - pressed ==0 or >1 bit (ghost/multi): rotate col_n 1110->1101->1011->0111->1110, dwell=0.
//  DEB_PRESS: pressed==captured row: cnt++. At cnt==DEBOUNCE_CYCLES-1, go to HELD and:
//   key_valid=1 for that one cycle; row_keys/col_keys load captured one-hots in the same cycle.
//   pressed!=captured row (bounce, different row): back to SCAN on next column, no pulse.
//  HELD: key_held=1; col_n frozen; other rows in the column are ignored.
//   Captured row releases (rows_s bit high) -> DEB_REL, cnt=0.
//  DEB_REL: captured row high for DEBOUNCE_CYCLES consecutive cycles -> SCAN, key_held=0,
//   next column. Row low again before then -> HELD, no new key_valid (bounce on release).
//  row_keys/col_keys hold last accepted key until next acceptance (decoder output stays stable).
//  Press-to-pulse latency: DEBOUNCE_CYCLES cycles after entering DEB_PRESS (+sync latency).
//  Counters sized $clog2(max(SCAN_CYCLES,DEBOUNCE_CYCLES)); they saturate, never wrap past target.
//  key_valid never asserts on consecutive cycles; at most one pulse per press-release cycle.
// CONFIGURATION
//  KEYPAD_SCANNER_SYNC_EN defined: row_n passes a 2-flop synchronizer into rows_s
//   (2-cycle latency, flops reset to 4'hF); SCAN_CYCLES must be >=3.
//  Not defined: row_n is registered once (1-cycle latency, resets to 4'hF); for
//   inputs already synchronous to clk (e.g. simulation).
// STRUCTURE
//  keypad_pkg: NUM_ROWS=4, NUM_COLS=4, typedef enum logic[1:0]
//   {SCAN, DEB_PRESS, HELD, DEB_REL} scan_state_t, COL_RESET=4'b1110.
//  Sub-module row_synchronizer (WIDTH, STAGES); STAGES=2 with the macro, 1 without.
//  Top: FSM, dwell counter, debounce counter, column rotator, output capture regs.
// TESTING  (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, both macro settings)
//  Reset 3 cycles, row_n=4'hF -> col_n=1110, rotates every 4 cycles, key_valid never high.
//  Hold row 2 low only while col_n=1011 -> one key_valid; row_keys=0100, col_keys=0100; key_held=1.
//  Press then bounce: row low 5 cycles, high 1 cycle -> no key_valid; scanning resumes on next col.
//  Release bounce: in HELD, row high 3 cycles, then low -> stays HELD, no second key_valid.
//  Rows 0 and 1 low together in column 0 -> treated as multi; column keeps rotating, no pulse.
//  Reset asserted during DEB_PRESS -> all outputs reset next cycle; col_n=1110; no pulse afterwards.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } scan_state_t;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    function automatic logic is_onehot(input logic [NUM_ROWS-1:0] v);
        logic [NUM_ROWS-1:0] one;
        one = {{(NUM_ROWS-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    // Active-low column walks 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [NUM_COLS-1:0] rotate_col(input logic [NUM_COLS-1:0] c);
        return {c[NUM_COLS-2:0], c[NUM_COLS-1]};
    endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Parameterized flop chain for the keypad row inputs; every stage resets to all-ones (idle rows).
module row_synchronizer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '1;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce feeding keypad_decoder.
// Define KEYPAD_SCANNER_SYNC_EN to pass rows through a 2-flop synchronizer (else 1 register).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_ROWS-1:0] row_n_i,
    output logic [NUM_COLS-1:0] col_n_o,
    output logic [NUM_ROWS-1:0] row_keys_o,
    output logic [NUM_COLS-1:0] col_keys_o,
    output logic                key_valid_o,
    output logic                key_held_o
);

    localparam int unsigned CntMax =
        (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] DwellLast = CntW'(SCAN_CYCLES - 1);
    localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

`ifdef KEYPAD_SCANNER_SYNC_EN
    localparam int unsigned SyncStages = 2;
`else
    localparam int unsigned SyncStages = 1;
`endif

    logic [NUM_ROWS-1:0] rows_s;
    logic [NUM_ROWS-1:0] pressed;

    scan_state_t         state_q, state_d;
    logic [CntW-1:0]     dwell_q, dwell_d;
    logic [CntW-1:0]     deb_q, deb_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [NUM_ROWS-1:0] cap_row_q, cap_row_d;
    logic [NUM_COLS-1:0] cap_col_q, cap_col_d;
    logic [NUM_ROWS-1:0] row_keys_q, row_keys_d;
    logic [NUM_COLS-1:0] col_keys_q, col_keys_d;
    logic                key_valid_q, key_valid_d;
    logic                row_released;

    row_synchronizer #(
        .WIDTH  (NUM_ROWS),
        .STAGES (SyncStages)
    ) u_row_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (row_n_i),
        .q_o     (rows_s)
    );

    assign pressed      = ~rows_s;
    assign row_released = (rows_s & cap_row_q) != '0;

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        col_n_d     = col_n_q;
        cap_row_d   = cap_row_q;
        cap_col_d   = cap_col_q;
        row_keys_d  = row_keys_q;
        col_keys_d  = col_keys_q;
        key_valid_d = 1'b0;

        unique case (state_q)
            SCAN: begin
                // Rows are only trusted on the last dwell cycle, after the sync latency settles.
                if (dwell_q >= DwellLast) begin
                    dwell_d = '0;
                    if (is_onehot(pressed)) begin
                        cap_row_d = pressed;
                        cap_col_d = ~col_n_q;
                        deb_d     = '0;
                        state_d   = DEB_PRESS;
                    end else begin
                        col_n_d = rotate_col(col_n_q);
                    end
                end else begin
                    dwell_d = dwell_q + CntOne;
                end
            end
            DEB_PRESS: begin
                if (pressed == cap_row_q) begin
                    if (deb_q >= DebLast) begin
                        state_d     = HELD;
                        key_valid_d = 1'b1;
                        row_keys_d  = cap_row_q;
                        col_keys_d  = cap_col_q;
                    end else begin
                        deb_d = deb_q + CntOne;
                    end
                end else begin
                    state_d = SCAN;
                    col_n_d = rotate_col(col_n_q);
                    dwell_d = '0;
                end
            end
            HELD: begin
                if (row_released) begin
                    state_d = DEB_REL;
                    deb_d   = '0;
                end
            end
            DEB_REL: begin
                if (row_released) begin
                    if (deb_q >= DebLast) begin
                        state_d = SCAN;
                        col_n_d = rotate_col(col_n_q);
                        dwell_d = '0;
                    end else begin
                        deb_d = deb_q + CntOne;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            deb_q       <= '0;
            col_n_q     <= COL_RESET;
            cap_row_q   <= '0;
            cap_col_q   <= '0;
            row_keys_q  <= '0;
            col_keys_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            col_n_q     <= col_n_d;
            cap_row_q   <= cap_row_d;
            cap_col_q   <= cap_col_d;
            row_keys_q  <= row_keys_d;
            col_keys_q  <= col_keys_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_n_o     = col_n_q;
    assign row_keys_o  = row_keys_q;
    assign col_keys_o  = col_keys_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = (state_q == HELD) || (state_q == DEB_REL);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a small keypad model drives rows from the driven column.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] row_keys;
    logic [3:0] col_keys;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys_down;  // bit r*4+c = key at row r, column c is pressed

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .row_n_i     (row_n),
        .col_n_o     (col_n),
        .row_keys_o  (row_keys),
        .col_keys_o  (col_keys),
        .key_valid_o (key_valid),
        .key_held_o  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (key_valid) pulses++;
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] c, input int n);
        logic [3:0] v;
        v = c;
        for (int i = 0; i < n; i++) v = {v[2:0], v[3]};
        return v;
    endfunction

    initial begin
        int t0;
        int t1;
        int p0;
        int held_low;
        int found;
        logic [3:0] seen;

        reset = 1'b1;
        keys_down = '0;
        repeat (3) step();
        check("rst_col_n", col_n, 4'b1110);
        check("rst_row_keys", row_keys, 4'b0000);
        check("rst_col_keys", col_keys, 4'b0000);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);

        // Idle scan: column advances every 4 cycles
        reset = 1'b0;
        pulses = 0;
        for (int i = 1; i < 20; i++) begin
            step();
            check($sformatf("rot_col_%0d", i), col_n, rotl(4'b1110, (i / 4) % 4));
        end
        check("rot_no_pulse", pulses, 0);

        // Press row 2 / column 2 and measure latency from column 2 becoming active
        keys_down[2*4+2] = 1'b1;
        p0 = pulses;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 60 && t1 < 0; i++) begin
            step();
            if (t0 < 0 && col_n == 4'b1011) t0 = cyc;
            if (key_valid) t1 = cyc;
        end
        check("press_seen", (t1 >= 0), 1'b1);
        check("press_latency", t1 - t0, 12);
        check("press_row_keys", row_keys, 4'b0100);
        check("press_col_keys", col_keys, 4'b0100);
        check("press_held", key_held, 1'b1);
        check("press_col_frozen", col_n, 4'b1011);
        step();
        check("press_pulse_1cyc", key_valid, 1'b0);
        check("press_one_pulse", pulses - p0, 1);

        // Release bounce: row high 3 cycles then low again
        p0 = pulses;
        keys_down[2*4+2] = 1'b0;
        repeat (3) step();
        keys_down[2*4+2] = 1'b1;
        held_low = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!key_held) held_low++;
        end
        check("relb_no_pulse", pulses - p0, 0);
        check("relb_stays_held", held_low, 0);
        check("relb_col_frozen", col_n, 4'b1011);

        // Real release
        keys_down[2*4+2] = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (!key_held) found = 1;
        end
        check("rel_done", found, 1);
        check("rel_next_col", col_n, 4'b0111);
        check("rel_row_keys_kept", row_keys, 4'b0100);
        check("rel_col_keys_kept", col_keys, 4'b0100);
        check("rel_no_pulse", pulses - p0, 0);

        // Press bounce on row 0 / column 3: low 5 cycles, high 1, low again
        p0 = pulses;
        keys_down[0*4+3] = 1'b1;
        repeat (5) step();
        check("pb_in_debounce", col_n, 4'b0111);
        keys_down[0*4+3] = 1'b0;
        step();
        keys_down[0*4+3] = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (col_n == 4'b1110) found = 1;
        end
        check("pb_scan_resumed", found, 1);
        check("pb_no_pulse", pulses - p0, 0);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            step();
            if (key_valid) found = 1;
        end
        check("pb_later_accept", found, 1);
        check("pb_row_keys", row_keys, 4'b0001);
        check("pb_col_keys", col_keys, 4'b1000);
        keys_down = '0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (!key_held) found = 1;
        end
        check("pb_released", found, 1);

        // Two rows low in column 0: ghost/multi, keep rotating
        p0 = pulses;
        keys_down[0*4+0] = 1'b1;
        keys_down[1*4+0] = 1'b1;
        seen = '0;
        held_low = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | ~col_n;
            if (key_held) held_low++;
        end
        check("multi_all_cols", seen, 4'b1111);
        check("multi_no_pulse", pulses - p0, 0);
        check("multi_never_held", held_low, 0);
        keys_down = '0;

        // Reset while debouncing row 3 / column 1
        keys_down[3*4+1] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (col_n == 4'b1101) found = 1;
        end
        check("rstdeb_col_reached", found, 1);
        repeat (7) step();
        check("rstdeb_in_debounce", col_n, 4'b1101);
        p0 = pulses;
        reset = 1'b1;
        keys_down = '0;
        step();
        check("rstdeb_col_n", col_n, 4'b1110);
        check("rstdeb_key_valid", key_valid, 1'b0);
        check("rstdeb_key_held", key_held, 1'b0);
        check("rstdeb_row_keys", row_keys, 4'b0000);
        check("rstdeb_col_keys", col_keys, 4'b0000);
        reset = 1'b0;
        repeat (30) step();
        check("rstdeb_no_pulse", pulses - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
